// File: rtl/regfile_arbiter.sv
// Two-port sequencer sharing one register file between the core (port A) and debug (port B).
// One transaction in flight; reads take ISSUE+WAIT, writes take ISSUE only, then RESP until consumed.
module regfile_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_write,
  input  logic [REG_W-1:0]  a_req_num_l,
  input  logic [REG_W-1:0]  a_req_num_r,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic [DATA_W-1:0] a_rsp_left,
  output logic [DATA_W-1:0] a_rsp_right,
  output logic              a_rsp_err,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_write,
  input  logic [REG_W-1:0]  b_req_num_l,
  input  logic [REG_W-1:0]  b_req_num_r,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] b_rsp_left,
  output logic [DATA_W-1:0] b_rsp_right,
  output logic              b_rsp_err,
  output logic [REG_W-1:0]  rf_left_num,
  output logic [REG_W-1:0]  rf_right_num,
  output logic [REG_W-1:0]  rf_write_num,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  input  logic [DATA_W-1:0] rf_left_data,
  input  logic [DATA_W-1:0] rf_right_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_b_q, grant_b_q, write_q;
  logic [REG_W-1:0]    num_l_q;
  logic [REG_W-1:0]    rf_left_num_q, rf_right_num_q, rf_write_num_q;
  logic [DATA_W-1:0]   rf_write_data_q;
  logic                rf_write_en_q;
  logic [DATA_W-1:0]   a_left_q, a_right_q, b_left_q, b_right_q;
  logic                a_err_q, b_err_q;

  logic                elig_a, elig_b, pick_b, accept, rsp_taken;
  logic                sel_write;
  logic [REG_W-1:0]    sel_num_l, sel_num_r;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    elig_a    = a_req_valid & ~halt;
    elig_b    = b_req_valid;
    // On a tie the port that did not win last time gets the grant.
    pick_b    = elig_b & (~elig_a | ~last_b_q);
    accept    = (state_q == IDLE) & (elig_a | elig_b);
    sel_write = pick_b ? b_req_write : a_req_write;
    sel_num_l = pick_b ? b_req_num_l : a_req_num_l;
    sel_num_r = pick_b ? b_req_num_r : a_req_num_r;
    sel_wdata = pick_b ? b_req_wdata : a_req_wdata;
    rsp_taken = grant_b_q ? b_rsp_ready : a_rsp_ready;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = write_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      last_b_q        <= 1'b1;
      grant_b_q       <= 1'b0;
      write_q         <= 1'b0;
      num_l_q         <= '0;
      rf_left_num_q   <= '0;
      rf_right_num_q  <= '0;
      rf_write_num_q  <= '0;
      rf_write_data_q <= '0;
      rf_write_en_q   <= 1'b0;
      a_left_q        <= '0;
      a_right_q       <= '0;
      a_err_q         <= 1'b0;
      b_left_q        <= '0;
      b_right_q       <= '0;
      b_err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            grant_b_q <= pick_b;
            last_b_q  <= pick_b;
            write_q   <= sel_write;
            num_l_q   <= sel_num_l;
            if (sel_write) begin
              // Writes to register 0 never reach the file.
              if (sel_num_l != '0) begin
                rf_write_num_q  <= sel_num_l;
                rf_write_data_q <= sel_wdata;
                rf_write_en_q   <= 1'b1;
              end
            end else begin
              rf_left_num_q  <= sel_num_l;
              rf_right_num_q <= sel_num_r;
            end
          end
        end
        ISSUE: begin
          rf_write_en_q <= 1'b0;
          if (write_q) begin
            if (grant_b_q) begin
              b_left_q  <= '0;
              b_right_q <= '0;
              b_err_q   <= (num_l_q == '0);
            end else begin
              a_left_q  <= '0;
              a_right_q <= '0;
              a_err_q   <= (num_l_q == '0);
            end
          end
        end
        WAIT: begin
          if (grant_b_q) begin
            b_left_q  <= rf_left_data;
            b_right_q <= rf_right_data;
            b_err_q   <= 1'b0;
          end else begin
            a_left_q  <= rf_left_data;
            a_right_q <= rf_right_data;
            a_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is masked by reset so nothing looks accepted while reset is held.
  assign a_req_ready   = accept & ~pick_b & ~reset;
  assign b_req_ready   = accept & pick_b & ~reset;
  assign a_rsp_valid   = (state_q == RESP) & ~grant_b_q;
  assign b_rsp_valid   = (state_q == RESP) & grant_b_q;
  assign a_rsp_left    = a_left_q;
  assign a_rsp_right   = a_right_q;
  assign a_rsp_err     = a_err_q;
  assign b_rsp_left    = b_left_q;
  assign b_rsp_right   = b_right_q;
  assign b_rsp_err     = b_err_q;
  assign rf_left_num   = rf_left_num_q;
  assign rf_right_num  = rf_right_num_q;
  assign rf_write_num  = rf_write_num_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_write_en   = rf_write_en_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a register-file model, a transaction-level reference
// checked every cycle, and directed scenarios with literal expectations.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        a_req_valid = 0, a_req_write = 0, a_rsp_ready = 1;
  logic [2:0]  a_req_num_l = 0, a_req_num_r = 0;
  logic [15:0] a_req_wdata = 0;
  logic        b_req_valid = 0, b_req_write = 0, b_rsp_ready = 1;
  logic [2:0]  b_req_num_l = 0, b_req_num_r = 0;
  logic [15:0] b_req_wdata = 0;
  logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err;
  logic [15:0] a_rsp_left, a_rsp_right, b_rsp_left, b_rsp_right;
  logic [2:0]  rf_left_num, rf_right_num, rf_write_num;
  logic [15:0] rf_write_data, rf_left_data, rf_right_data;
  logic        rf_write_en;

  int total = 0;
  int bad = 0;

  regfile_arbiter #(.DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_num_l(a_req_num_l), .a_req_num_r(a_req_num_r), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_left(a_rsp_left),
    .a_rsp_right(a_rsp_right), .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_num_l(b_req_num_l), .b_req_num_r(b_req_num_r), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_left(b_rsp_left),
    .b_rsp_right(b_rsp_right), .b_rsp_err(b_rsp_err),
    .rf_left_num(rf_left_num), .rf_right_num(rf_right_num), .rf_write_num(rf_write_num),
    .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .rf_left_data(rf_left_data), .rf_right_data(rf_right_data)
  );

  always #5 clk = ~clk;

  // Register file: registered read, reads only when no write is presented.
  logic [15:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    mem[2] = 16'h1234;
    mem[5] = 16'hBEEF;
    rf_left_data  = 16'h0;
    rf_right_data = 16'h0;
  end
  always @(posedge clk) begin
    if (rf_write_en) mem[rf_write_num] <= rf_write_data;
    else begin
      rf_left_data  <= mem[rf_left_num];
      rf_right_data <= mem[rf_right_num];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction phase counted from the accept cycle.
  logic [15:0] gm [8];
  bit          m_busy = 0, m_last_b = 1, m_pb = 0, m_wr = 0, m_err = 0;
  int          m_k = 0;
  logic [2:0]  m_nl = 0, m_ln = 0, m_rn = 0, m_wn = 0;
  logic [15:0] m_wd = 0, m_left = 0, m_right = 0;
  initial begin
    for (int i = 0; i < 8; i++) gm[i] = 16'h0;
    gm[2] = 16'h1234;
    gm[5] = 16'hBEEF;
  end

  always @(negedge clk) begin
    bit ea, eb, gb, e_ar, e_br, e_av, e_bv, e_we;
    int rstart;
    if (reset) begin
      chk("rst_a_req_ready", a_req_ready, 0);
      chk("rst_b_req_ready", b_req_ready, 0);
      chk("rst_a_rsp_valid", a_rsp_valid, 0);
      chk("rst_b_rsp_valid", b_rsp_valid, 0);
      chk("rst_rf_write_en", rf_write_en, 0);
      chk("rst_rf_nums", {rf_left_num, rf_right_num, rf_write_num}, 0);
      m_busy = 0; m_last_b = 1; m_ln = 0; m_rn = 0; m_wn = 0; m_wd = 0;
    end else begin
      e_ar = 0; e_br = 0; e_av = 0; e_bv = 0; e_we = 0; gb = 0; rstart = 3;
      if (!m_busy) begin
        ea = a_req_valid && !halt;
        eb = b_req_valid;
        gb = eb && (!ea || !m_last_b);
        e_ar = ea && !gb;
        e_br = gb;
      end else begin
        rstart = m_wr ? 2 : 3;
        e_we = m_wr && (m_nl != 0) && (m_k == 1);
        if (m_k >= rstart) begin
          e_av = !m_pb;
          e_bv = m_pb;
        end
      end
      chk("a_req_ready", a_req_ready, e_ar);
      chk("b_req_ready", b_req_ready, e_br);
      chk("a_rsp_valid", a_rsp_valid, e_av);
      chk("b_rsp_valid", b_rsp_valid, e_bv);
      chk("rf_write_en", rf_write_en, e_we);
      chk("rf_read_nums", {rf_left_num, rf_right_num}, {m_ln, m_rn});
      chk("rf_write_num_data", {rf_write_num, rf_write_data}, {m_wn, m_wd});
      if (e_av) chk("a_rsp_data", {a_rsp_err, a_rsp_left, a_rsp_right}, {m_err, m_left, m_right});
      if (e_bv) chk("b_rsp_data", {b_rsp_err, b_rsp_left, b_rsp_right}, {m_err, m_left, m_right});
      if (!m_busy) begin
        if (e_ar || e_br) begin
          m_busy = 1; m_k = 1; m_pb = e_br; m_last_b = e_br;
          m_wr = e_br ? b_req_write : a_req_write;
          m_nl = e_br ? b_req_num_l : a_req_num_l;
          if (m_wr) begin
            m_left = 0; m_right = 0; m_err = (m_nl == 0);
            if (m_nl != 0) begin
              m_wn = m_nl;
              m_wd = e_br ? b_req_wdata : a_req_wdata;
              gm[m_nl] = m_wd;
            end
          end else begin
            m_ln = m_nl;
            m_rn = e_br ? b_req_num_r : a_req_num_r;
            m_left = gm[m_ln]; m_right = gm[m_rn]; m_err = 0;
          end
        end
      end else if (m_k >= rstart && (m_pb ? b_rsp_ready : a_rsp_ready)) begin
        m_busy = 0;
      end else begin
        m_k++;
      end
    end
  end

  // Log of DUT-side accepts (0 = A, 1 = B).
  bit acc_q[$];
  always @(negedge clk) begin
    if (a_req_valid && a_req_ready) acc_q.push_back(1'b0);
    if (b_req_valid && b_req_ready) acc_q.push_back(1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit pb, input bit v, input bit wr, input logic [2:0] nl,
                         input logic [2:0] nr, input logic [15:0] wd);
    if (pb) begin
      b_req_valid = v; b_req_write = wr; b_req_num_l = nl; b_req_num_r = nr; b_req_wdata = wd;
    end else begin
      a_req_valid = v; a_req_write = wr; a_req_num_l = nl; a_req_num_r = nr; a_req_wdata = wd;
    end
  endtask

  // Issue one transaction on a port with the other port idle; report data, latency, write strobes.
  task automatic run_txn(input bit pb, input bit wr, input logic [2:0] nl, input logic [2:0] nr,
                         input logic [15:0] wd, output logic [15:0] l, output logic [15:0] r,
                         output logic err, output int lat, output int we_cnt);
    int n;
    set_req(pb, 1, wr, nl, nr, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pb ? b_req_ready : a_req_ready) && n < 50);
    if (n >= 50) chk("accept_timeout", 1, 0);
    tick();
    set_req(pb, 0, 0, 3'd7, 3'd7, 16'hDEAD);
    lat = 0; we_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (rf_write_en) we_cnt++;
    end while (!(pb ? b_rsp_valid : a_rsp_valid) && lat < 50);
    l = pb ? b_rsp_left : a_rsp_left;
    r = pb ? b_rsp_right : a_rsp_right;
    err = pb ? b_rsp_err : a_rsp_err;
    tick();
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_ready"}, {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid}, 0);
    chk({tag, "_rsp_a"}, {a_rsp_err, a_rsp_left, a_rsp_right}, 0);
    chk({tag, "_rsp_b"}, {b_rsp_err, b_rsp_left, b_rsp_right}, 0);
    chk({tag, "_rf"}, {rf_write_en, rf_left_num, rf_right_num, rf_write_num, rf_write_data}, 0);
  endtask

  initial begin
    logic [15:0] l, r;
    logic        err;
    int          lat, wec, n0, cnt;

    // Reset with both ports requesting: everything must read zero.
    set_req(0, 1, 0, 3'd2, 3'd5, 16'h0);
    set_req(1, 1, 0, 3'd5, 3'd2, 16'h0);
    repeat (3) tick();
    zero_outputs("reset");
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    reset = 0;
    tick();

    // A reads r2/r5.
    run_txn(0, 0, 3'd2, 3'd5, 16'h0, l, r, err, lat, wec);
    chk("a_read_left", l, 16'h1234);
    chk("a_read_right", r, 16'hBEEF);
    chk("a_read_latency", lat, 3);

    // B writes r6 then reads r6/r0.
    run_txn(1, 1, 3'd6, 3'd0, 16'h0040, l, r, err, lat, wec);
    chk("b_write_we_cycles", wec, 1);
    chk("b_write_latency", lat, 2);
    chk("b_write_rsp", {err, l, r}, 0);
    run_txn(1, 0, 3'd6, 3'd0, 16'h0, l, r, err, lat, wec);
    chk("b_read_r6", l, 16'h0040);
    chk("b_read_r0", r, 16'h0000);

    // A writes r0: rejected.
    run_txn(0, 1, 3'd0, 3'd0, 16'hFFFF, l, r, err, lat, wec);
    chk("a_w0_err", err, 1);
    chk("a_w0_we_cycles", wec, 0);
    chk("a_w0_latency", lat, 2);
    run_txn(0, 0, 3'd0, 3'd2, 16'h0, l, r, err, lat, wec);
    chk("a_read_r0", l, 16'h0000);
    chk("a_read_r2", r, 16'h1234);

    // Fresh reset, then both ports request continuously.
    reset = 1;
    tick();
    reset = 0;
    acc_q.delete();
    set_req(0, 1, 0, 3'd2, 3'd5, 16'h0);
    set_req(1, 1, 0, 3'd5, 3'd6, 16'h0);
    repeat (18) tick();
    chk("rr_grant_count_ge4", acc_q.size() >= 4, 1);
    if (acc_q.size() >= 4) chk("rr_sequence", {acc_q[0], acc_q[1], acc_q[2], acc_q[3]}, 4'b0101);

    // Halt: only B, then A first once halt drops.
    halt = 1;
    repeat (6) tick();
    acc_q.delete();
    repeat (12) tick();
    cnt = 0;
    foreach (acc_q[i]) if (acc_q[i] == 1'b0) cnt++;
    chk("halt_a_grants", cnt, 0);
    chk("halt_b_grants_ge2", acc_q.size() >= 2, 1);
    n0 = acc_q.size();
    halt = 0;
    repeat (10) tick();
    chk("halt_release_count", acc_q.size() > n0, 1);
    if (acc_q.size() > n0) chk("halt_release_first_a", acc_q[n0], 0);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (6) tick();

    // B response stalled for 10 cycles while A waits.
    b_rsp_ready = 0;
    set_req(1, 1, 0, 3'd2, 3'd5, 16'h0);
    n0 = 0;
    do begin
      @(negedge clk);
      n0++;
    end while (!b_req_ready && n0 < 50);
    if (n0 >= 50) chk("stall_accept_timeout", 1, 0);
    tick();
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 0, 3'd5, 3'd2, 16'h0);
    acc_q.delete();
    repeat (2) tick();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_rsp_valid) cnt++;
      tick();
    end
    chk("stall_rsp_held", cnt, 10);
    chk("stall_no_grant", acc_q.size(), 0);
    b_rsp_ready = 1;
    n0 = 0;
    do begin
      @(negedge clk);
      n0++;
    end while (!a_req_ready && n0 < 20);
    chk("pending_a_granted", a_req_ready, 1);
    tick();
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    // Now in the read's wait cycle: reset mid-cycle.
    set_req(0, 1, 0, 3'd2, 3'd5, 16'h0);
    set_req(1, 1, 0, 3'd5, 3'd2, 16'h0);
    reset = 1;
    #1;
    zero_outputs("async_reset");
    tick();
    acc_q.delete();
    reset = 0;
    repeat (3) tick();
    chk("post_reset_grant_count", acc_q.size() >= 1, 1);
    if (acc_q.size() >= 1) chk("post_reset_tie_a", acc_q[0], 0);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
